// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and a selectable first-word-fall-through read mode.
//
// Ports
//   clk           rising-edge clock for all state
//   reset         synchronous active-high reset (clears data_out too)
//   flush         synchronous clear of contents/flags; data_out holds
//   wr_en         write request, data_in captured when accepted
//   data_in       write data
//   rd_en         read request
//   data_out      read data (registered, or head-of-queue when FWFT=1)
//   full / empty  count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write request was rejected
//   underflow     sticky: a read request was rejected
//
// Handshake: wr_en/rd_en are requests and full/empty act as the inverse
// ready. A read is accepted when rd_en & ~empty. A write is accepted when
// wr_en & (~full | read accepted), so a full FIFO can take a write in the
// same cycle it is popped. An empty FIFO never bypasses a write to the
// read side. A rejected request is dropped and raises its sticky flag.
//
// DEPTH must be a power of two >= 4; AF_LEVEL and AE_LEVEL lie in 0..DEPTH.

module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Status flags come straight from registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (wr_en & ~wr_acc);
    underflow_d = underflow_q | (rd_en & ~rd_acc);
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; only pointers and count are reset.
  always_ff @(posedge clk) begin
    if (!reset && !flush && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented combinationally; zero while empty.
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] data_q;
      // Registered read: flush leaves the last word visible, reset clears it.
      always_ff @(posedge clk) begin
        if (reset)                data_q <= '0;
        else if (!flush && rd_acc) data_q <= mem_q[rd_ptr_q];
      end
      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
// Directed bench for sync_fifo_param. Two instances share all inputs:
// dut0 uses the registered read mode, dut1 the first-word-fall-through mode.
// Inputs change 1 time unit after the rising edge; outputs are observed at
// that same point, i.e. they reflect the edge just taken.

module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset, flush, wr_en, rd_en;
  logic [7:0] data_in;

  logic [7:0] data_out0, data_out1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (count0 !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count0); end
    tests_run++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin tests_failed++; $display("FAIL reset_flags got %b exp 1010", {empty0, full0, ae0, af0}); end
    tests_run++; if ({ovf0, unf0} !== 2'b00) begin tests_failed++; $display("FAIL reset_err got %b exp 00", {ovf0, unf0}); end
    tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("FAIL reset_dout0 got %h exp 00", data_out0); end
    tests_run++; if ({data_out1, empty1} !== 9'h001) begin tests_failed++; $display("FAIL reset_dut1 got %h exp 001", {data_out1, empty1}); end
  endtask

  // Three writes, then two reads with one-cycle read latency.
  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; data_in = vals[i];
      cycle();
    end
    wr_en = 1'b0;
    tests_run++; if (count0 !== 5'd3) begin tests_failed++; $display("FAIL basic_count3 got %0d exp 3", count0); end
    tests_run++; if (data_out1 !== 8'hA1) begin tests_failed++; $display("FAIL basic_fwft_head got %h exp a1", data_out1); end
    rd_en = 1'b1;
    cycle();
    tests_run++; if (data_out0 !== 8'hA1) begin tests_failed++; $display("FAIL basic_rd0 got %h exp a1", data_out0); end
    tests_run++; if (count0 !== 5'd2) begin tests_failed++; $display("FAIL basic_count2 got %0d exp 2", count0); end
    cycle();
    rd_en = 1'b0;
    tests_run++; if (data_out0 !== 8'hB2) begin tests_failed++; $display("FAIL basic_rd1 got %h exp b2", data_out0); end
    tests_run++; if (count0 !== 5'd1) begin tests_failed++; $display("FAIL basic_count1 got %0d exp 1", count0); end
    tests_run++; if (empty0 !== 1'b0) begin tests_failed++; $display("FAIL basic_empty got %b exp 0", empty0); end
    cycle();
    tests_run++; if (data_out0 !== 8'hB2) begin tests_failed++; $display("FAIL basic_hold got %h exp b2", data_out0); end
  endtask

  // Fill to full watching thresholds, overflow on 17th write, drain in order.
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = 8'(i);
      cycle();
      tests_run++;
      if ({count0, ae0, af0, full0} !== {5'(i + 1), (i + 1 <= 4), (i + 1 >= 12), (i + 1 == 16)}) begin
        tests_failed++;
        $display("FAIL fill_flags[%0d] got cnt=%0d ae=%b af=%b full=%b exp cnt=%0d ae=%b af=%b full=%b",
                 i, count0, ae0, af0, full0, i + 1, (i + 1 <= 4), (i + 1 >= 12), (i + 1 == 16));
      end
    end
    data_in = 8'hFF;
    cycle();
    wr_en = 1'b0;
    tests_run++; if ({ovf0, count0} !== {1'b1, 5'd16}) begin tests_failed++; $display("FAIL fill_overflow got ovf=%b cnt=%0d exp ovf=1 cnt=16", ovf0, count0); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      tests_run++; if (data_out0 !== 8'(i)) begin tests_failed++; $display("FAIL fill_drain[%0d] got %h exp %h", i, data_out0, 8'(i)); end
    end
    rd_en = 1'b0;
    tests_run++; if ({empty0, unf0} !== 2'b10) begin tests_failed++; $display("FAIL fill_end got empty=%b unf=%b exp 1 0", empty0, unf0); end
  endtask

  // Full FIFO with simultaneous read and write, then drain across the wrap.
  task automatic test_back_to_back();
    logic [7:0] exp_v;
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 8'(i);
      cycle();
    end
    rd_en = 1'b1; data_in = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      cycle();
      tests_run++;
      if ({data_out0, count0, ovf0} !== {8'(i), 5'd16, 1'b0}) begin
        tests_failed++;
        $display("FAIL b2b_rw[%0d] got dout=%h cnt=%0d ovf=%b exp dout=%h cnt=16 ovf=0", i, data_out0, count0, ovf0, 8'(i));
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = (i < 12) ? 8'(i + 4) : 8'hAA;
      tests_run++; if (data_out1 !== exp_v) begin tests_failed++; $display("FAIL b2b_fwft[%0d] got %h exp %h", i, data_out1, exp_v); end
      cycle();
      tests_run++; if (data_out0 !== exp_v) begin tests_failed++; $display("FAIL b2b_drain[%0d] got %h exp %h", i, data_out0, exp_v); end
    end
    rd_en = 1'b0;
    tests_run++; if ({empty0, ovf0, unf0} !== 3'b100) begin tests_failed++; $display("FAIL b2b_end got %b exp 100", {empty0, ovf0, unf0}); end
  endtask

  // Read and write on an empty FIFO: read rejected, no bypass.
  task automatic test_underflow();
    do_reset();
    rd_en = 1'b1; wr_en = 1'b1; data_in = 8'h55;
    cycle();
    rd_en = 1'b0; wr_en = 1'b0;
    tests_run++; if ({unf0, count0} !== {1'b1, 5'd1}) begin tests_failed++; $display("FAIL unf_set got unf=%b cnt=%0d exp unf=1 cnt=1", unf0, count0); end
    tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("FAIL unf_nobypass got %h exp 00", data_out0); end
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    tests_run++; if ({data_out0, count0, unf0} !== {8'h55, 5'd0, 1'b1}) begin tests_failed++; $display("FAIL unf_read got dout=%h cnt=%0d unf=%b exp 55 0 1", data_out0, count0, unf0); end
  endtask

  task automatic test_fwft();
    do_reset();
    wr_en = 1'b1; data_in = 8'h3C;
    tests_run++; if ({data_out1, empty1} !== 9'h001) begin tests_failed++; $display("FAIL fwft_pre got %h exp 001", {data_out1, empty1}); end
    cycle();
    wr_en = 1'b0;
    tests_run++; if ({data_out1, empty1} !== {8'h3C, 1'b0}) begin tests_failed++; $display("FAIL fwft_show got dout=%h empty=%b exp 3c 0", data_out1, empty1); end
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    tests_run++; if ({data_out1, empty1} !== 9'h001) begin tests_failed++; $display("FAIL fwft_pop got dout=%h empty=%b exp 00 1", data_out1, empty1); end
  endtask

  task automatic test_flush();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      data_in = 8'h20 + 8'(i);
      cycle();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    rd_en = 1'b0;
    tests_run++; if ({count0, ovf0, data_out0} !== {5'd5, 1'b1, 8'h2A}) begin tests_failed++; $display("FAIL flush_pre got cnt=%0d ovf=%b dout=%h exp 5 1 2a", count0, ovf0, data_out0); end
    flush = 1'b1; wr_en = 1'b1; data_in = 8'h77;
    cycle();
    flush = 1'b0; wr_en = 1'b0;
    tests_run++; if ({count0, empty0, ovf0} !== {5'd0, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL flush_clear got cnt=%0d empty=%b ovf=%b exp 0 1 0", count0, empty0, ovf0); end
    tests_run++; if (data_out0 !== 8'h2A) begin tests_failed++; $display("FAIL flush_hold got %h exp 2a", data_out0); end
    rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    tests_run++; if (unf0 !== 1'b1) begin tests_failed++; $display("FAIL flush_unf got %b exp 1", unf0); end
    wr_en = 1'b1; data_in = 8'h50;
    cycle();
    data_in = 8'h51;
    cycle();
    reset = 1'b1; data_in = 8'h52;
    cycle();
    reset = 1'b0; wr_en = 1'b0;
    tests_run++; if ({count0, empty0, unf0, ovf0} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL midreset got cnt=%0d empty=%b unf=%b ovf=%b exp 0 1 0 0", count0, empty0, unf0, ovf0); end
    tests_run++; if (data_out0 !== 8'h00) begin tests_failed++; $display("FAIL midreset_dout got %h exp 00", data_out0); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    #1;
    test_reset();
    test_basic();
    test_fill();
    test_back_to_back();
    test_underflow();
    test_fwft();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
